// File: rtl/a429_rx_fifo.sv
// ARINC429 receive-word FIFO: circular word buffer between the receiver and the host read port.
// Optional per-label acceptance table enabled by defining A429_RX_LBL_FILTER_EN.
module a429_rx_fifo #(
   parameter int ADDR_W   = 5,
   parameter int AF_LEVEL = 24
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rf_wr,
   input  logic [31:0]       rf_di,
   output logic              rf_fl,
   input  logic              clr_i,
   input  logic              rd_i,
   output logic [31:0]       rd_dat_o,
   output logic              rd_vld_o,
   output logic              empty_o,
   output logic              afull_o,
   output logic [ADDR_W:0]   cnt_o,
   output logic              ovf_o,
   input  logic              ovf_clr_i,
   input  logic              lbl_wr_i,
   input  logic [7:0]        lbl_adr_i,
   input  logic              lbl_dat_i
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t              state_r, state_nxt_s;
   logic [31:0]         mem_r [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic [ADDR_W:0]     cnt_r, cnt_nxt_s;
   logic [31:0]         rd_dat_r, rd_dat_nxt_s;
   logic                rd_vld_r, rd_vld_nxt_s;
   logic                ovf_r, ovf_nxt_s;
   logic                full_r, empty_r, afull_r;
   logic                flush_s, lbl_ok_s, wr_acc_s, rd_acc_s, drop_s;

`ifdef A429_RX_LBL_FILTER_EN
   logic [255:0] lbl_en_r;

   // Label-enable table; lookups in the same cycle see the pre-write value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lbl_en_r <= '1;
      end else if (lbl_wr_i) begin
         lbl_en_r[lbl_adr_i] <= lbl_dat_i;
      end else begin
         lbl_en_r <= lbl_en_r;
      end
   end

   assign lbl_ok_s = lbl_en_r[rf_di[7:0]];
`else
   logic unused_lbl_s;
   assign unused_lbl_s = ^{lbl_wr_i, lbl_adr_i, lbl_dat_i};
   assign lbl_ok_s     = 1'b1;
`endif

   // Per-cycle accept/drop decisions and next-state values.
   always_comb begin
      flush_s      = clr_i || (state_r == ST_FLUSH);
      wr_acc_s     = rf_wr && lbl_ok_s && (cnt_r < DEPTH_C) && !flush_s;
      drop_s       = rf_wr && lbl_ok_s && (cnt_r == DEPTH_C) && !flush_s;
      rd_acc_s     = rd_i && (cnt_r != '0) && !flush_s;
      state_nxt_s  = clr_i ? ST_FLUSH : ST_RUN;
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      cnt_nxt_s    = cnt_r;
      rd_dat_nxt_s = rd_dat_r;
      rd_vld_nxt_s = 1'b0;
      ovf_nxt_s    = ovf_r;
      if (flush_s) begin
         wr_ptr_nxt_s = '0;
         rd_ptr_nxt_s = '0;
         cnt_nxt_s    = '0;
         ovf_nxt_s    = 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (rd_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + ADDR_W'(1);
            rd_dat_nxt_s = mem_r[rd_ptr_r];
            rd_vld_nxt_s = 1'b1;
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   cnt_nxt_s = cnt_r + ONE_C;
            2'b01:   cnt_nxt_s = cnt_r - ONE_C;
            default: cnt_nxt_s = cnt_r;
         endcase
         // A drop in the same cycle as ovf_clr_i keeps the flag set.
         if (drop_s) begin
            ovf_nxt_s = 1'b1;
         end else if (ovf_clr_i) begin
            ovf_nxt_s = 1'b0;
         end else begin
            ovf_nxt_s = ovf_r;
         end
      end
   end

   // Word storage; no reset, contents are only read after being written.
   always_ff @(posedge clk_i) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r] <= rf_di;
      end
   end

   // Flush sequencer, pointers, count, read port and registered flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r  <= ST_RUN;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
         rd_dat_r <= 32'h0000_0000;
         rd_vld_r <= 1'b0;
         ovf_r    <= 1'b0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         afull_r  <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         cnt_r    <= cnt_nxt_s;
         rd_dat_r <= rd_dat_nxt_s;
         rd_vld_r <= rd_vld_nxt_s;
         ovf_r    <= ovf_nxt_s;
         full_r   <= (cnt_nxt_s == DEPTH_C);
         empty_r  <= (cnt_nxt_s == '0);
         afull_r  <= (cnt_nxt_s >= AF_C);
      end
   end

   assign rf_fl    = full_r;
   assign empty_o  = empty_r;
   assign afull_o  = afull_r;
   assign cnt_o    = cnt_r;
   assign ovf_o    = ovf_r;
   assign rd_dat_o = rd_dat_r;
   assign rd_vld_o = rd_vld_r;

endmodule

// File: doc/a429_rx_fifo.md
Name: a429_rx_fifo

Overview:
- Receive-word buffer directly downstream of the ARINC429 receiver. It consumes the receiver's 32-bit word writes and holds them for host software.
- Buffers decoded words in a circular RAM, drives the full flag back to the receiver, and flags overflow and almost-full conditions.
- Presents a registered, one-cycle-latency read port to the host register interface.
- Optionally drops words whose label is not enabled in a per-label table.

Parameters:
- ADDR_W, 5, log2 of FIFO depth; DEPTH = 2**ADDR_W (default 32 words).
- AF_LEVEL, 24, almost-full threshold in words; range 1..DEPTH.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- rf_wr  in  1  write strobe from receiver, one-cycle pulse per decoded word.
- rf_di  in  32  received word; label in bits [7:0].
- rf_fl  out  1  FIFO full, fed back to the receiver.
- clr_i  in  1  synchronous flush.
- rd_i  in  1  host read request.
- rd_dat_o  out  32  read data.
- rd_vld_o  out  1  rd_dat_o valid, one-cycle pulse.
- empty_o  out  1  FIFO empty.
- afull_o  out  1  count >= AF_LEVEL.
- cnt_o  out  ADDR_W+1  stored word count, 0..DEPTH.
- ovf_o  out  1  sticky overflow.
- ovf_clr_i  in  1  clear ovf_o.
- lbl_wr_i  in  1  label-table write (feature only).
- lbl_adr_i  in  8  label-table address (feature only).
- lbl_dat_i  in  1  label-table enable bit (feature only).

Behaviour:
- Reset (async, rst_i=1):
  - Pointers and count go to 0; rd_dat_o=0, rd_vld_o=0, ovf_o=0.
  - Flags go to empty_o=1, rf_fl=0, afull_o=0.
- Storage: wr_ptr/rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0. The count register is ADDR_W+1 bits.
- Flags:
  - All flags are decoded from the registered count, never from same-cycle requests.
  - rf_fl = (cnt==DEPTH); empty_o = (cnt==0); afull_o = (cnt>=AF_LEVEL).
  - Flags update in the cycle after the accepted write or read.
- Write acceptance:
  - A write is accepted iff rf_wr=1, cnt<DEPTH, clr_i=0, and the label check passes.
  - On accept: mem[wr_ptr]<=rf_di and wr_ptr increments.
- Overflow:
  - rf_wr=1 with cnt==DEPTH drops the word and sets ovf_o the next cycle.
  - A read in that same cycle does not rescue the word.
- Read:
  - rd_i=1 with cnt>0: rd_dat_o<=mem[rd_ptr], rd_vld_o=1 next cycle, rd_ptr increments.
  - rd_i with cnt==0 is ignored: rd_vld_o=0 and rd_dat_o holds.
- Simultaneous accepted write and read: cnt unchanged and both pointers advance. A read at cnt==1 with a same-cycle write returns the old word.
- Write/read data-path phase, cycle behaviour: IDLE/ACCEPT/DROP is combinational per cycle, with no multi-cycle FSM in the data path.
- Flush sequencer FSM:
  - ST_RUN: clr_i=1 -> ST_FLUSH.
  - ST_FLUSH: one cycle; pointers and cnt go to 0, ovf_o=0, rd_vld_o=0; all rf_wr and rd_i are ignored -> ST_RUN.
  - clr_i held high keeps the FSM in ST_FLUSH.
- ovf_clr_i:
  - Clears ovf_o next cycle.
  - If a drop occurs in the same cycle, the set wins and ovf_o stays 1.
- RAM: no reset required; contents are undefined after reset and never observable before a write.
- Reset mid-operation: an immediate async clear to the reset state, independent of clk_i. The FSM returns to ST_RUN.

Optional Feature:
- Macro: A429_RX_LBL_FILTER_EN.
- Defined:
  - Adds a 256x1 label-enable table, reset to all 1s (all labels pass).
  - lbl_wr_i writes lbl_dat_i to entry lbl_adr_i on the clock edge.
  - An incoming word is accepted only if table[rf_di[7:0]]=1. A filtered word is dropped silently, does not set ovf_o and does not change cnt.
  - A table write to the same label in the same cycle as rf_wr uses the old table value.
- Not defined: lbl_* ports exist but are ignored; every word passes the label check.

Test Plan:
- Reset then write 0x12345683, rf_wr one cycle -> cnt_o=1, empty_o=0 next cycle. rd_i -> rd_vld_o=1 with rd_dat_o=0x12345683 one cycle later, then empty_o=1.
- Write 32 words 0x00000000..0x0000001F -> rf_fl=1, afull_o=1 from cnt=24. A 33rd write 0xDEADBEEF is dropped and ovf_o=1. Reading 32 words returns 0x00..0x1F in order.
- At cnt=32, rf_wr and rd_i in the same cycle -> write dropped, ovf_o=1, cnt=31. ovf_clr_i pulse -> ovf_o=0.
- Pointer wrap: write and read 40 words interleaved at cnt<=2 -> data order preserved across the 31->0 wrap; cnt never exceeds 2.
- With 10 words stored, pulse clr_i -> cnt_o=0, empty_o=1, ovf_o=0. A rd_i on the next cycle gives no rd_vld_o.
- Assert rst_i asynchronously mid-write (between edges) -> outputs go to reset values immediately.
- A429_RX_LBL_FILTER_EN defined: write lbl_adr_i=0x83, lbl_dat_i=0, then words with label 0x83 and 0x84 -> only the 0x84 word is stored, cnt=1, ovf_o=0.
